// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with a registered valid/ready grant.
// Requester index i sits on bit [7-i] so the grant feeds the 8-to-3 one-hot
// encoder directly (bit 7 = index 0). The grant is one-hot while grant_valid is
// high and all-zero otherwise.
// Optional feature: define ARB_LOCK_EN to let one requester hold the grant for
// up to HOLD_MAX consecutive accepts while it keeps requesting.
module rr_arbiter8 #(
    parameter int unsigned PTR_RESET = 0,
    parameter int unsigned HOLD_MAX  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       grant_ready,
    output logic [7:0] grant,
    output logic       grant_valid
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned REQ_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [REQ_W-1:0]   grant_q, grant_d;
    logic               valid_q, valid_d;
`ifdef ARB_LOCK_EN
    logic [IDX_W-1:0]   cnt_q,   cnt_d;
`endif

    logic               req_any;
    logic [IDX_W-1:0]   next_ptr;

    // First requesting index in the order p, p+1, ..., p+7 (mod 8).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [REQ_W-1:0] r,
                                                  input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] idx;
        rr_pick = p;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            idx = p + IDX_W'(i);
            if (r[IDX_W'(REQ_W - 1) - idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // Index i maps to bit [7-i] of the one-hot grant.
    function automatic logic [REQ_W-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        to_onehot = REQ_W'(8'h80) >> idx;
    endfunction

    assign req_any  = |req;
    assign next_ptr = idx_q + IDX_W'(1);

    // Next-state: pick a winner from idle, or hold / rotate on an accepted offer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
`ifdef ARB_LOCK_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    idx_d   = rr_pick(req, ptr_q);
                    grant_d = to_onehot(idx_d);
                    valid_d = 1'b1;
                    state_d = OFFER;
`ifdef ARB_LOCK_EN
                    cnt_d   = IDX_W'(1);
`endif
                end
            end
            OFFER: begin
                if (grant_ready) begin
`ifdef ARB_LOCK_EN
                    if (req[IDX_W'(REQ_W - 1) - idx_q] && (cnt_q < IDX_W'(HOLD_MAX))) begin
                        // Same requester keeps the grant; pointer stays put.
                        cnt_d = cnt_q + IDX_W'(1);
                    end else
`endif
                    begin
                        ptr_d = next_ptr;
                        if (req_any) begin
                            idx_d   = rr_pick(req, next_ptr);
                            grant_d = to_onehot(idx_d);
`ifdef ARB_LOCK_EN
                            cnt_d   = IDX_W'(1);
`endif
                        end else begin
                            grant_d = '0;
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears any pending offer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(PTR_RESET);
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
`ifdef ARB_LOCK_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
`ifdef ARB_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic,
// all checked against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int unsigned HOLD = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_ready;
    logic [7:0] grant;
    logic       grant_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_ptr;
    int m_idx;
    int m_cnt;
    bit m_valid;

    rr_arbiter8 #(
        .PTR_RESET (0),
        .HOLD_MAX  (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_ready (grant_ready),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner = first requesting index in order ptr, ptr+1, ... (mod 8).
    function automatic int model_win(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = (p + i) % 8;
            if (r[7 - idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_grant();
        logic [7:0] g;
        g = 8'h00;
        if (m_valid) g[7 - m_idx] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rdy);
        bit hold;
        if (!m_valid) begin
            if (r != 8'h00) begin
                m_idx   = model_win(r, m_ptr);
                m_valid = 1'b1;
                m_cnt   = 1;
            end
        end else if (rdy) begin
            hold = 1'b0;
`ifdef ARB_LOCK_EN
            hold = r[7 - m_idx] && (m_cnt < HOLD);
`endif
            if (hold) begin
                m_cnt++;
            end else begin
                m_ptr = (m_idx + 1) % 8;
                if (r != 8'h00) begin
                    m_idx = model_win(r, m_ptr);
                    m_cnt = 1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, compare 1 time unit later.
    task automatic cycle(input logic [7:0] r, input logic rdy, input string tag);
        req         = r;
        grant_ready = rdy;
        @(posedge clk);
        model_step(r, rdy);
        #1;
        check_eq({tag, "_grant"}, 32'(grant), 32'(model_grant()));
        check_eq({tag, "_valid"}, 32'(grant_valid), 32'(m_valid));
    endtask

    task automatic do_reset();
        req         = 8'h00;
        grant_ready = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    logic [7:0] exp_seq [0:8];
    logic [7:0] r;
    logic       rdy;

    initial begin
        do_reset();
        check_eq("reset_grant", 32'(grant), 32'h00);
        check_eq("reset_valid", 32'(grant_valid), 32'h0);

        // Idle after reset
        for (int i = 0; i < 10; i++) cycle(8'h00, 1'b1, "idle");

        // Two requesters, continuous accept
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(8'b1000_0001, 1'b1, "two_req");
`ifndef ARB_LOCK_EN
            check_eq("two_req_const", 32'(grant), (i % 2 == 0) ? 32'h80 : 32'h01);
`endif
        end

        // Backpressure: single request held across 5 stalled cycles
        do_reset();
        cycle(8'b0010_0000, 1'b0, "bp_load");
        for (int i = 0; i < 4; i++) begin
            cycle(8'h00, 1'b0, "bp_hold");
            check_eq("bp_hold_const", 32'(grant), 32'h20);
        end
        cycle(8'h00, 1'b1, "bp_accept");
        check_eq("bp_after_grant", 32'(grant), 32'h00);
        check_eq("bp_after_valid", 32'(grant_valid), 32'h0);
        // ptr should now be 3: full load wins at index 3
        cycle(8'hFF, 1'b0, "bp_ptr");
        check_eq("bp_ptr_const", 32'(grant), 32'h10);

        // Full load and pointer wrap
        do_reset();
        exp_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b1, "full");
`ifndef ARB_LOCK_EN
            check_eq("full_const", 32'(grant), 32'(exp_seq[i]));
`else
            check_eq("lock_const", 32'(grant), 32'(exp_seq[i / 2]));
`endif
        end

`ifdef ARB_LOCK_EN
        // Lock released by dropping the held request after its first accept
        do_reset();
        cycle(8'hFF, 1'b1, "lock_drop_a");
        check_eq("lock_drop_first", 32'(grant), 32'h80);
        cycle(8'h7F, 1'b1, "lock_drop_b");
        check_eq("lock_drop_next", 32'(grant), 32'h40);
`endif

        // Asynchronous reset in the middle of an offer
        do_reset();
        cycle(8'h10, 1'b0, "ar_load");
        check_eq("ar_offer", 32'(grant), 32'h10);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("ar_grant", 32'(grant), 32'h00);
        check_eq("ar_valid", 32'(grant_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'hFF, 1'b1, "ar_restart");
        check_eq("ar_restart_const", 32'(grant), 32'h80);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r   = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            rdy = ($urandom_range(0, 9) < 7);
            cycle(r, rdy, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter with a registered valid/ready grant output.
- Sits directly upstream of the team's 8-to-3 one-hot encoder and feeds it the `grant` vector.
- `grant` is guaranteed one-hot while `grant_valid` is high and all-zero otherwise, so the encoder never decodes an illegal multi-hot pattern.
- Bit order matches the encoder: requester index i is on bit [7-i], so bit 7 is index 0 and encodes to 3'b000.

Parameters:
- PTR_RESET, default 0: priority pointer value after reset (index 0..7).
- HOLD_MAX, default 4: maximum consecutive grants to one requester. Used only when ARB_LOCK_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  request vector; index i on bit [7-i].
- grant_ready  input  1  downstream accepts the current grant.
- grant  output  8  registered one-hot grant; 8'h00 when not valid.
- grant_valid  output  1  grant offer pending.

Behaviour:
- Reset (rst_n=0, asynchronous): grant=8'h00, grant_valid=0, ptr=PTR_RESET, state=IDLE. Takes effect immediately, including mid-offer. Release is synchronous to clk.
- Internal state: 3-bit pointer `ptr`. Search order is ptr, ptr+1, ..., ptr+7, all mod 8; the first index with its req bit high wins.
- IDLE state:
  - grant_valid=0.
  - If req != 0 at a rising edge: register the winner's one-hot grant, set grant_valid=1, go to OFFER. Latency from req to valid is 1 cycle.
  - If req == 0: stay in IDLE.
- OFFER state:
  - grant and grant_valid are held stable until grant_valid && grant_ready is sampled at a rising edge.
  - The offer is committed: a requester dropping req does not withdraw it.
  - On accept of index k:
    - ptr <= k+1 mod 8 (7 wraps to 0).
    - Re-search the same-cycle req starting at the new ptr.
    - If any bit is set: load the new grant and stay in OFFER. Throughput is 1 grant per cycle.
    - Otherwise: clear grant, drop grant_valid, go to IDLE.
  - Index k, if still requesting, is last in the new search order. If it is the only requester it wins again.
- ptr changes only on an accepted handshake, never on an unaccepted offer.
- Simultaneous accept and new requests: the re-search uses req as sampled in that same cycle.
- No combinational path from req or grant_ready to any output. All outputs are registered.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - A 3-bit hold counter tracks consecutive accepts of the same index k.
  - On accept, if req[7-k] is still high and the count < HOLD_MAX, re-offer k next cycle; ptr is not advanced and the count increments.
  - Otherwise rotate as normal: ptr <= k+1 and the count resets to 1 on the new winner.
  - Reset clears the counter.
- Undefined: strict rotation after every accept; no counter logic is present.

Test Plan:
- Idle after reset: assert rst_n=0 then release, req=8'h00 for 10 cycles -> grant=8'h00 and grant_valid=0 throughout.
- Two requesters, continuous accept: PTR_RESET=0, req=8'b1000_0001, grant_ready=1 -> grant sequence 8'h80, 8'h01, 8'h80, 8'h01, ... with grant_valid=1 every cycle from the 1st edge onward.
- Backpressure: req=8'b0010_0000 for 1 cycle then 8'h00, grant_ready=0 for 5 cycles then 1 -> grant=8'h20 with valid=1 held all 5 cycles. After the accept edge: grant=8'h00, valid=0, ptr=3.
- Full load and wrap: req=8'hFF, grant_ready=1 -> grants 80,40,20,10,08,04,02,01,80 on successive cycles, confirming the ptr 7->0 wrap.
- Asynchronous reset mid-offer: assert rst_n=0 between clock edges while grant=8'h10 and valid=1 -> grant=8'h00 and valid=0 before the next edge. After release, arbitration restarts from PTR_RESET.
- Lock enabled: ARB_LOCK_EN defined, HOLD_MAX=2, req=8'hFF, ready=1 -> grants 80,80,40,40,20,20,...
- Lock released by req drop: same setup, drop req bit 7 after its 1st accept -> next grant is 8'h40.
